// File: rtl/vga_frame_source.sv
// VGA raster generator streaming RGB565 pixels from a show-ahead line FIFO.
// Define FRAME_SOURCE_TESTPAT_EN to build in the test_mode colour-bar generator.
module vga_frame_source #(
    parameter int          H_PIXEL         = 1024,
    parameter int          V_PIXEL         = 768,
    parameter int          H_FP            = 24,
    parameter int          H_SYNC          = 136,
    parameter int          H_BP            = 160,
    parameter int          V_FP            = 3,
    parameter int          V_SYNC          = 6,
    parameter int          V_BP            = 29,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        test_mode,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        frame_vsync,
    output logic        frame_hsync,
    output logic        frame_de,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [15:0] pixel_data,
    output logic        frame_start,
    output logic        underflow
);

    localparam logic [10:0] H_ACT  = 11'(H_PIXEL);
    localparam logic [10:0] H_SS   = 11'(H_PIXEL + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_PIXEL + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_PIXEL + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(V_PIXEL);
    localparam logic [10:0] V_SS   = 11'(V_PIXEL + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_PIXEL + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_PIXEL + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic [15:0] pix_q, pix_d;
    logic        fs_q, fs_d;
    logic        uf_q, uf_d;

    logic        counting;
    logic        h_end;
    logic        frame_end;
    logic        de_pre;
    logic        bar_active;
    logic [15:0] bar_color;

`ifdef FRAME_SOURCE_TESTPAT_EN
    always_comb begin
        bar_active = test_mode;
        bar_color  = 16'h0000;
        case (h_cnt_q[9:7])
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign bar_active       = 1'b0;
    assign bar_color        = 16'h0000;
`endif

    assign counting  = (state_q != IDLE);
    assign h_end     = (h_cnt_q == H_LAST);
    assign frame_end = h_end && (v_cnt_q == V_LAST);
    assign de_pre    = counting && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    assign fifo_rd_en = de_pre && !fifo_empty && !bar_active && !rst;

    // A frame wrap only continues into a new frame when en is high at that moment
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (frame_end)  state_d = en ? RUN : IDLE;
                else if (!en)   state_d = DRAIN;
            end
            DRAIN: begin
                if (frame_end)  state_d = en ? RUN : IDLE;
                else if (en)    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (counting) begin
            h_cnt_d = h_end ? 11'd0 : h_cnt_q + 11'd1;
            if (h_end) v_cnt_d = frame_end ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        hsync_d = !(counting && (h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
        vsync_d = !(counting && (v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
        de_d    = de_pre;
        xpos_d  = de_pre ? h_cnt_q : 11'd0;
        ypos_d  = de_pre ? v_cnt_q : 11'd0;
        pix_d   = 16'h0000;
        if (de_pre) begin
            if (bar_active)       pix_d = bar_color;
            else if (!fifo_empty) pix_d = fifo_rd_data;
            else                  pix_d = UNDERFLOW_COLOR;
        end
        fs_d = de_pre && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        uf_d = uf_q | (de_pre && fifo_empty && !bar_active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            xpos_q  <= 11'd0;
            ypos_q  <= 11'd0;
            pix_q   <= 16'h0000;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            pix_q   <= pix_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

    assign frame_hsync = hsync_q;
    assign frame_vsync = vsync_q;
    assign frame_de    = de_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign pixel_data  = pix_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_vga_frame_source.sv
// Scoreboard bench for vga_frame_source on a shrunken 25x10 raster.
// Pixels are queued as expected when a frame is launched and popped on frame_de.
module tb_vga_frame_source;

    localparam int HP = 16;

    logic        clk = 1'b0;
    logic        rst, en, test_mode;
    logic        fifo_rd_en, fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        frame_vsync, frame_hsync, frame_de;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [15:0] pixel_data;
    logic        frame_start, underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] d;
    } pix_t;

    pix_t exp_q[$];

    logic [15:0] fifo_word = 16'd0;

    always #5 clk = ~clk;

    vga_frame_source #(
        .H_PIXEL(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_PIXEL(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .test_mode(test_mode),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
        .frame_de(frame_de), .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos), .pixel_data(pixel_data),
        .frame_start(frame_start), .underflow(underflow)
    );

    // Show-ahead FIFO holding an incrementing word stream
    assign fifo_rd_data = fifo_word;
    always @(posedge clk) if (fifo_rd_en) fifo_word <= fifo_word + 16'd1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int npix, input int uf_y, input int uf_x0,
                              input int uf_n, input int w_in, output int w_out);
        pix_t p;
        int   w;
        w = w_in;
        for (int k = 0; k < npix; k++) begin
            p.x = 11'(k % HP);
            p.y = 11'(k / HP);
            if ((k / HP) == uf_y && (k % HP) >= uf_x0 && (k % HP) < uf_x0 + uf_n)
                p.d = 16'hF800;
            else begin
                p.d = 16'(w);
                w++;
            end
            exp_q.push_back(p);
        end
        w_out = w;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hsync"}, frame_hsync, 1);
        chk({tag, "_vsync"}, frame_vsync, 1);
        chk({tag, "_de"},    frame_de, 0);
        chk({tag, "_xpos"},  pixel_xpos, 0);
        chk({tag, "_ypos"},  pixel_ypos, 0);
        chk({tag, "_data"},  pixel_data, 0);
        chk({tag, "_fs"},    frame_start, 0);
        chk({tag, "_uf"},    underflow, 0);
        chk({tag, "_rden"},  fifo_rd_en, 0);
    endtask

    always @(negedge clk) begin : monitor
        pix_t e;
        if (frame_de === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pixel x=%0d y=%0d required none",
                         pixel_xpos, pixel_ypos);
            end else begin
                e = exp_q.pop_front();
                chk("sb_x",    pixel_xpos, e.x);
                chk("sb_y",    pixel_ypos, e.y);
                chk("sb_data", pixel_data, e.d);
            end
        end
        if (frame_start === 1'b1) begin
            chk("fs_de",     frame_de, 1);
            chk("fs_origin", {pixel_xpos, pixel_ypos}, 0);
        end
    end

    initial begin
        int w, o;
        int de_l0, hs_l0, hs_first, de_f0, vs_f0, vs_first;
        int de_f1, vs_f1, fs_n, fs_a, fs_b, idle_bad;
        de_l0 = 0; hs_l0 = 0; hs_first = -1; de_f0 = 0; vs_f0 = 0;
        vs_first = -1; de_f1 = 0; vs_f1 = 0; fs_n = 0; fs_a = -1;
        fs_b = -1; idle_bad = 0;

        rst = 1'b1; en = 1'b0; test_mode = 1'b0; fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_init");

        push_frame(96, 1, 5, 3, 0, w);
        push_frame(96, -1, 0, 0, w, w);
        en = 1'b1;

        for (int c = 0; c <= 600; c++) begin
            @(negedge clk);
            o = c - 1;
            if (c >= 1 && c <= 510) begin
                if (o < 25) begin
                    de_l0 += int'(frame_de);
                    if (!frame_hsync) begin
                        hs_l0++;
                        if (hs_first < 0) hs_first = o;
                    end
                end
                if (o < 250) begin
                    de_f0 += int'(frame_de);
                    if (!frame_vsync) begin
                        vs_f0++;
                        if (vs_first < 0) vs_first = o;
                    end
                end else if (o < 500) begin
                    de_f1 += int'(frame_de);
                    if (!frame_vsync) vs_f1++;
                end else if (frame_de || !frame_hsync || !frame_vsync || frame_start)
                    idle_bad++;
                if (frame_start) begin
                    fs_n++;
                    if (fs_a < 0) fs_a = o;
                    else fs_b = o;
                end
            end
            if (c == 30)  chk("uf_before",  underflow, 0);
            if (c == 31)  chk("uf_set",     underflow, 1);
            if (c == 511) chk("fs_restart_early", frame_start, 0);
            if (c == 512) chk("fs_restart", frame_start, 1);
            if (c == 597) check_reset("rst_mid");

            fifo_empty = (c >= 30 && c <= 32);
`ifndef FRAME_SOURCE_TESTPAT_EN
            test_mode = (c >= 250 && c < 500);
`endif
            if (c == 350) en = 1'b0;
            if (c == 510) begin
                push_frame(58, -1, 0, 0, w, w);
                en = 1'b1;
            end
            if (c == 596) rst = 1'b1;
            if (c == 597) en = 1'b0;
            if (c == 598) rst = 1'b0;

            #1;
            if (c == 0)   chk("rden_active", fifo_rd_en, 1);
            if (c == 16)  chk("rden_blank",  fifo_rd_en, 0);
            if (c == 29)  chk("rden_pre_uf", fifo_rd_en, 1);
            if (c >= 30 && c <= 32) chk("rden_uf", fifo_rd_en, 0);
            if (c == 260) chk("rden_testmode_ignored", fifo_rd_en, 1);
            if (c == 505) begin
                chk("rden_idle", fifo_rd_en, 0);
                chk("uf_sticky", underflow, 1);
            end
        end

        chk("de_line0",    de_l0, 16);
        chk("hs_low_len",  hs_l0, 3);
        chk("hs_offset",   hs_first, 18);
        chk("de_frame0",   de_f0, 96);
        chk("vs_low_len",  vs_f0, 50);
        chk("vs_offset",   vs_first, 175);
        chk("de_frame1",   de_f1, 96);
        chk("vs_low_len1", vs_f1, 50);
        chk("fs_count",    fs_n, 2);
        chk("frame_period", fs_b - fs_a, 250);
        chk("idle_quiet",  idle_bad, 0);
        chk("sb_drained",  exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
